// File: rtl/ps2_key_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_sequencer_if
// Description : Scan-byte input, event FIFO and key-state bundle for the
//               PS/2 key sequencer.
// Revision    : 1.0
// ============================================================================
interface ps2_key_sequencer_if;
  logic [7:0] scan_data;
  logic       scan_valid;
  logic       clear;
  logic       evt_pop;
  logic [2:0] evt_key;
  logic       evt_valid;
  logic       evt_overflow;
  logic [5:0] key_held;
  logic [5:0] key_press;
  logic [1:0] dir_code;
  logic       dir_valid;

  modport master (
    output scan_data, scan_valid, clear, evt_pop,
    input  evt_key, evt_valid, evt_overflow, key_held, key_press, dir_code, dir_valid
  );

  modport slave (
    input  scan_data, scan_valid, clear, evt_pop,
    output evt_key, evt_valid, evt_overflow, key_held, key_press, dir_code, dir_valid
  );
endinterface
`default_nettype wire

// File: rtl/ps2_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_sequencer
// Description : PS/2 scan-byte parser, held-key tracker, press-event FIFO and
//               most-recent-wins direction arbiter for six game keys.
// Revision    : 1.0
// ============================================================================
module ps2_key_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int PREFIX_TIMEOUT = 1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  ps2_key_sequencer_if.slave bus
);
  localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W  = c_ADDR_W + 1;
  localparam int c_TMO_W  = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST  = c_TMO_W'(PREFIX_TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_FIFO_FULL = c_CNT_W'(FIFO_DEPTH);
  localparam logic [7:0] c_PFX_EXT = 8'hE0;
  localparam logic [7:0] c_PFX_BRK = 8'hF0;
  localparam logic [7:0] c_PAUSE   = 8'hE1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_TMO_W-1:0]   r_tmo_cnt, w_tmo_cnt_nxt;
  logic                 w_key_act, w_is_break, w_is_ext;
  logic [3:0]           w_dec;
  logic                 w_key_hit;
  logic [2:0]           w_key_idx;
  logic [5:0]           w_onehot;
  logic                 w_make_new, w_break_hit;
  logic [5:0]           r_key_held, w_held_nxt, r_key_press;
  logic [1:0]           r_dir_code, w_dir_nxt;
  logic [2:0]           r_mem [FIFO_DEPTH];
  logic [c_ADDR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic                 r_overflow;
  logic                 w_push, w_push_ok, w_pop;

  // Returns {hit, key_index} for a make/break code.
  function automatic logic [3:0] f_key_decode(input logic is_ext, input logic [7:0] code);
    logic [3:0] v;
    v = 4'd0;
    if (is_ext) begin
      case (code)
        8'h75:   v = 4'b1_000;
        8'h72:   v = 4'b1_001;
        8'h6B:   v = 4'b1_010;
        8'h74:   v = 4'b1_011;
        8'h5A:   v = 4'b1_101;
        default: v = 4'd0;
      endcase
    end else begin
      case (code)
        8'h1D:   v = 4'b1_000;
        8'h1B:   v = 4'b1_001;
        8'h1C:   v = 4'b1_010;
        8'h23:   v = 4'b1_011;
        8'h29:   v = 4'b1_100;
        8'h5A:   v = 4'b1_101;
        default: v = 4'd0;
      endcase
    end
    return v;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_tmo_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tmo_cnt <= w_tmo_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_key_act   = 1'b0;
    w_is_break  = 1'b0;
    w_is_ext    = 1'b0;
    if (bus.clear) begin
      w_state_nxt = S_IDLE;
    end else if (bus.scan_valid) begin
      // Pause bytes are transparent to the prefix state.
      if (bus.scan_data != c_PAUSE) begin
        case (r_state)
          S_IDLE: begin
            if (bus.scan_data == c_PFX_EXT)      w_state_nxt = S_EXT;
            else if (bus.scan_data == c_PFX_BRK) w_state_nxt = S_BRK;
            else                                 w_key_act   = 1'b1;
          end
          S_EXT: begin
            if (bus.scan_data == c_PFX_BRK) begin
              w_state_nxt = S_EXT_BRK;
            end else if (bus.scan_data != c_PFX_EXT) begin
              w_key_act   = 1'b1;
              w_is_ext    = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
          S_BRK: begin
            w_key_act   = 1'b1;
            w_is_break  = 1'b1;
            w_state_nxt = S_IDLE;
          end
          default: begin
            w_key_act   = 1'b1;
            w_is_break  = 1'b1;
            w_is_ext    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        endcase
      end
    end else if (r_state != S_IDLE && r_tmo_cnt == c_TMO_LAST) begin
      w_state_nxt = S_IDLE;
    end
    w_tmo_cnt_nxt = (bus.scan_valid || w_state_nxt == S_IDLE) ? '0 : r_tmo_cnt + c_TMO_W'(1);
  end

  assign w_dec       = f_key_decode(w_is_ext, bus.scan_data);
  assign w_key_hit   = w_dec[3];
  assign w_key_idx   = w_dec[2:0];
  assign w_onehot    = 6'b1 << w_key_idx;
  assign w_make_new  = w_key_act && !w_is_break && w_key_hit && !(|(r_key_held & w_onehot));
  assign w_break_hit = w_key_act && w_is_break && w_key_hit;

  always_comb begin
    w_held_nxt = r_key_held;
    if (bus.clear)        w_held_nxt = '0;
    else if (w_make_new)  w_held_nxt = r_key_held | w_onehot;
    else if (w_break_hit) w_held_nxt = r_key_held & ~w_onehot;

    // A fresh direction make wins; losing the current one falls back to priority.
    w_dir_nxt = r_dir_code;
    if (w_make_new && !w_key_idx[2]) begin
      w_dir_nxt = w_key_idx[1:0];
    end else if (!w_held_nxt[r_dir_code]) begin
      if (w_held_nxt[0])      w_dir_nxt = 2'd0;
      else if (w_held_nxt[1]) w_dir_nxt = 2'd1;
      else if (w_held_nxt[2]) w_dir_nxt = 2'd2;
      else if (w_held_nxt[3]) w_dir_nxt = 2'd3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key_held  <= '0;
      r_key_press <= '0;
      r_dir_code  <= 2'd0;
    end else begin
      r_key_held  <= w_held_nxt;
      r_key_press <= w_make_new ? w_onehot : 6'd0;
      r_dir_code  <= w_dir_nxt;
    end
  end

  assign w_push    = w_make_new;
  assign w_pop     = bus.evt_pop && (r_count != '0) && !bus.clear;
  assign w_push_ok = w_push && ((r_count != c_FIFO_FULL) || w_pop);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_key_idx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (bus.clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
      if (w_push_ok && !w_pop)      r_count <= r_count + c_CNT_W'(1);
      else if (!w_push_ok && w_pop) r_count <= r_count - c_CNT_W'(1);
      if (w_push && !w_push_ok) r_overflow <= 1'b1;
    end
  end

  assign bus.evt_valid    = (r_count != '0);
  assign bus.evt_key      = (r_count != '0) ? r_mem[r_rd_ptr] : 3'd0;
  assign bus.evt_overflow = r_overflow;
  assign bus.key_held     = r_key_held;
  assign bus.key_press    = r_key_press;
  assign bus.dir_code     = r_dir_code;
  assign bus.dir_valid    = |r_key_held[3:0];

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_sequencer.sv
`default_nettype none
// Bench for ps2_key_sequencer: directed scenarios plus random byte streams
// compared cycle by cycle against a byte-level reference model.
module tb_ps2_key_sequencer;
  localparam int FIFO_DEPTH     = 4;
  localparam int PREFIX_TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  ps2_key_sequencer_if bus ();

  ps2_key_sequencer #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .PREFIX_TIMEOUT (PREFIX_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: prefix flags, quiet-cycle count, key and event state.
  bit         m_ext, m_brk;
  int         m_quiet;
  logic [5:0] m_held, m_press;
  int         m_fifo[$];
  bit         m_ovf;
  int         m_dir;

  logic [7:0] pool [14] = '{8'hE0, 8'hF0, 8'hE1, 8'h1D, 8'h1B, 8'h1C, 8'h23,
                            8'h29, 8'h5A, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hF0};

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int keymap(input bit ext, input logic [7:0] code);
    case ({ext, code})
      9'h01D, 9'h175: return 0;
      9'h01B, 9'h172: return 1;
      9'h01C, 9'h16B: return 2;
      9'h023, 9'h174: return 3;
      9'h029:         return 4;
      9'h05A, 9'h15A: return 5;
      default:        return -1;
    endcase
  endfunction

  function automatic logic [7:0] pick_byte();
    int i;
    i = $urandom_range(0, 15);
    if (i >= 14) return 8'($urandom_range(0, 255));
    return pool[i];
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_quiet = 0;
    m_held = '0; m_press = '0; m_fifo.delete(); m_ovf = 0; m_dir = 0;
  endtask

  task automatic model_step(input logic sv, input logic [7:0] sd, input logic clr, input logic pop);
    bit push;
    int k;
    m_press = '0;
    push = 0;
    if (clr) begin
      m_ext = 0; m_brk = 0; m_quiet = 0; m_held = '0; m_fifo.delete(); m_ovf = 0;
      return;
    end
    if (sv) begin
      m_quiet = 0;
      if (sd == 8'hE1) begin
        // pause byte: no effect
      end else if (!m_brk && sd == 8'hE0) begin
        m_ext = 1;
      end else if (!m_brk && sd == 8'hF0) begin
        m_brk = 1;
      end else begin
        k = keymap(m_ext, sd);
        if (k >= 0) begin
          if (m_brk) m_held[k] = 1'b0;
          else if (!m_held[k]) begin
            m_held[k] = 1'b1; m_press[k] = 1'b1; push = 1;
            if (k < 4) m_dir = k;
          end
        end
        m_ext = 0; m_brk = 0;
      end
    end else if (m_ext || m_brk) begin
      m_quiet++;
      if (m_quiet >= PREFIX_TIMEOUT) begin m_ext = 0; m_brk = 0; m_quiet = 0; end
    end
    if (!m_held[m_dir]) begin
      for (int i = 0; i < 4; i++) if (m_held[i]) begin m_dir = i; break; end
    end
    if (pop && m_fifo.size() > 0) void'(m_fifo.pop_front());
    if (push) begin
      if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(k);
      else m_ovf = 1;
    end
  endtask

  task automatic compare_all();
    check("key_held",     bus.key_held,     m_held);
    check("key_press",    bus.key_press,    m_press);
    check("evt_valid",    bus.evt_valid,    m_fifo.size() != 0);
    if (m_fifo.size() != 0) check("evt_key", bus.evt_key, m_fifo[0]);
    check("evt_overflow", bus.evt_overflow, m_ovf);
    check("dir_code",     bus.dir_code,     m_dir);
    check("dir_valid",    bus.dir_valid,    |m_held[3:0]);
  endtask

  task automatic cyc(input logic sv, input logic [7:0] sd, input logic clr, input logic pop);
    bus.scan_valid = sv; bus.scan_data = sd; bus.clear = clr; bus.evt_pop = pop;
    @(posedge clk); #1;
    model_step(sv, sd, clr, pop);
    bus.scan_valid = 1'b0; bus.clear = 1'b0; bus.evt_pop = 1'b0;
    compare_all();
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    int e3 [4] = '{4, 5, 1, 2};
    int e5 [4] = '{5, 1, 2, 3};
    int r;

    reset = 1'b0;
    bus.scan_valid = 1'b0; bus.scan_data = 8'h00; bus.clear = 1'b0; bus.evt_pop = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_evt_key",   bus.evt_key, 0);
    check("rst_evt_valid", bus.evt_valid, 0);
    check("rst_overflow",  bus.evt_overflow, 0);
    check("rst_held",      bus.key_held, 0);
    check("rst_press",     bus.key_press, 0);
    check("rst_dir_code",  bus.dir_code, 0);
    check("rst_dir_valid", bus.dir_valid, 0);
    reset = 1'b1;

    // Typematic repeats produce a single event.
    cyc(1, 8'h1D, 0, 0); cyc(1, 8'h1D, 0, 0); cyc(1, 8'h1D, 0, 0);
    check("tp1_held", bus.key_held, 6'b000001);
    check("tp1_key",  bus.evt_key, 0);

    // Most recent direction wins, then falls back after release.
    cyc(0, 0, 1, 0);
    cyc(1, 8'hE0, 0, 0); cyc(1, 8'h74, 0, 0);
    check("tp2_dir_right", bus.dir_code, 3);
    cyc(1, 8'h1D, 0, 0);
    check("tp2_dir_up", bus.dir_code, 0);
    cyc(1, 8'hF0, 0, 0); cyc(1, 8'h1D, 0, 0);
    check("tp2_dir_back", bus.dir_code, 3);
    check("tp2_held", bus.key_held, 6'b001000);

    // Overflow while full, then drain in order.
    cyc(0, 0, 1, 0);
    cyc(1, 8'h29, 0, 0); cyc(1, 8'h5A, 0, 0); cyc(1, 8'h1B, 0, 0);
    cyc(1, 8'h1C, 0, 0); cyc(1, 8'h23, 0, 0);
    check("tp3_overflow", bus.evt_overflow, 1);
    for (int i = 0; i < 4; i++) begin
      check("tp3_head", bus.evt_key, e3[i]);
      cyc(0, 0, 0, 1);
    end
    check("tp3_empty", bus.evt_valid, 0);

    // Prefix timeout: exactly PREFIX_TIMEOUT quiet cycles drops the E0.
    cyc(0, 0, 1, 0);
    cyc(1, 8'hE0, 0, 0);
    repeat (PREFIX_TIMEOUT) cyc(0, 0, 0, 0);
    cyc(1, 8'h72, 0, 0);
    check("tp4_held", bus.key_held, 0);
    check("tp4_valid", bus.evt_valid, 0);
    cyc(1, 8'hE0, 0, 0);
    repeat (PREFIX_TIMEOUT - 1) cyc(0, 0, 0, 0);
    cyc(1, 8'h72, 0, 0);
    check("tp4_ext_held", bus.key_held, 6'b000010);

    // Push and pop together while full.
    cyc(0, 0, 1, 0);
    cyc(1, 8'h29, 0, 0); cyc(1, 8'h5A, 0, 0); cyc(1, 8'h1B, 0, 0); cyc(1, 8'h1C, 0, 0);
    cyc(1, 8'h23, 0, 1);
    check("tp5_head", bus.evt_key, 5);
    check("tp5_overflow", bus.evt_overflow, 0);
    for (int i = 0; i < 4; i++) begin
      check("tp5_drain", bus.evt_key, e5[i]);
      cyc(0, 0, 0, 1);
    end
    check("tp5_empty", bus.evt_valid, 0);

    // Clear coincident with F0: the byte is dropped.
    cyc(0, 0, 1, 0);
    cyc(1, 8'h1D, 0, 0); cyc(1, 8'h1B, 0, 0); cyc(1, 8'h1C, 0, 0);
    cyc(1, 8'h23, 0, 0); cyc(1, 8'h29, 0, 0);
    cyc(1, 8'hF0, 1, 0);
    check("tp6_held", bus.key_held, 0);
    check("tp6_valid", bus.evt_valid, 0);
    check("tp6_overflow", bus.evt_overflow, 0);
    cyc(1, 8'h1D, 0, 0);
    check("tp6_make", bus.key_held, 6'b000001);
    check("tp6_press", bus.key_press, 6'b000001);

    // Reset between E0 and 75.
    cyc(1, 8'hE0, 0, 0);
    do_reset();
    cyc(1, 8'h75, 0, 0);
    check("rst_mid_held", bus.key_held, 0);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      if (r < 4) begin
        repeat (PREFIX_TIMEOUT + 2) cyc(0, 0, 0, 0);
      end else if (r < 6) begin
        cyc(1'($urandom_range(0, 1)), pick_byte(), 1, 1'($urandom_range(0, 1)));
      end else if (r == 6) begin
        do_reset();
      end else begin
        cyc(1'($urandom_range(0, 1)), pick_byte(), 0, ($urandom_range(0, 3) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ps2_key_sequencer.md
Name: ps2_key_sequencer

Overview:
Sequences the raw PS/2 scan-byte stream from the PS/2 receiver into game-level key state. It parses the E0 (extended) and F0 (break) prefixes and tracks the held state of six game keys. It emits one-shot press events, with typematic repeats suppressed, into a small event FIFO. It also arbitrates simultaneous direction keys into a single "most recent wins" direction for the game FSM.

Parameters:
FIFO_DEPTH, 4, event FIFO entries; power of two, 2..16.
PREFIX_TIMEOUT, 1_000_000, clk cycles allowed between a prefix byte and its following byte; 20 ms at 50 MHz.

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low reset
scan_data  in  8  received PS/2 byte
scan_valid  in  1  1-cycle strobe, scan_data valid
clear  in  1  synchronous flush: held state, FIFO, parser, arbiter
evt_pop  in  1  consumer pops FIFO head
evt_key  out  3  FIFO head key index
evt_valid  out  1  FIFO non-empty
evt_overflow  out  1  sticky; a push was dropped while full
key_held  out  6  current held state per key index
key_press  out  6  1-cycle pulse on a new make per key index
dir_code  out  2  arbitrated direction: 0 up, 1 down, 2 left, 3 right
dir_valid  out  1  at least one direction key held

Behaviour:
- Key index map, make codes:
  - 0 up: 1D, or E0 75
  - 1 down: 1B, or E0 72
  - 2 left: 1C, or E0 6B
  - 3 right: 23, or E0 74
  - 4 space: 29
  - 5 enter: 5A, or E0 5A
  - Any other code is parsed, then ignored.
- Parser FSM states: IDLE, EXT, BRK, EXT_BRK. Each transition happens on a scan_valid cycle.
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte is a make, returns to IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay in EXT; any other byte is an extended make -> IDLE.
  - BRK: any byte is a break -> IDLE.
  - EXT_BRK: any byte is an extended break -> IDLE.
  - E1 (Pause) in any state is ignored and does not change state.
- Prefix timeout: a counter clears on every scan_valid. In any state other than IDLE, reaching PREFIX_TIMEOUT forces IDLE with no key action.
- Make of mapped key k:
  - If key_held[k] is 0: on the next cycle, key_held[k] is set to 1, key_press[k] pulses high for exactly one cycle, k is pushed to the FIFO, and k becomes the last direction (k ≤ 3 only).
  - If key_held[k] is already 1 (typematic repeat): no pulse, no push.
- Break of mapped key k: key_held[k] is cleared to 0 on the next cycle. No event is generated. A break of a key that is not held is harmless.
- Latency: byte strobe -> key_held, key_press, and FIFO all update 1 cycle later. dir_code and dir_valid update in the same cycle as key_held.
- Direction arbiter:
  - dir_code is the most recently made direction that is still held.
  - When that key is released, dir_code falls back to fixed priority among the remaining held directions: up > down > left > right.
  - dir_valid = OR of key_held[3:0].
  - When dir_valid is 0, dir_code holds its last value.
- Event FIFO:
  - evt_key and evt_valid are first-word-fall-through.
  - A pop while empty is ignored.
  - A push while full is dropped and sets evt_overflow. evt_overflow clears only on reset or clear.
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Push and pop in the same cycle while empty: the push succeeds and the pop is ignored.
- clear has priority over every other action in its cycle, and any scan byte in that cycle is dropped. It zeroes key_held, FIFO pointers and count, and evt_overflow, and returns the parser to IDLE. dir_code is not cleared.
- Reset values: every output is 0, the parser is in IDLE, and the FIFO is empty. Assertion of reset takes effect immediately, including mid-sequence (for example between E0 and 75).

Test Plan:
1. Bytes 1D, 1D, 1D (typematic) -> key_held[0]=1; exactly one key_press[0] pulse; FIFO holds one entry, evt_key=0; dir_code=0, dir_valid=1.
2. Bytes E0 74, then 1D, then F0 1D -> dir_code goes 3, then 0, then back to 3 after the break; key_held toggles accordingly.
3. Makes 29, 5A, 1B, 1C, 23 with FIFO_DEPTH=4 and no pops -> FIFO contains 4,5,1,2; the push of 3 is dropped and evt_overflow=1; popping 4 times drains in order, then evt_valid=0.
4. Byte E0, then PREFIX_TIMEOUT idle cycles, then 72 -> treated as a plain make of 72, which is unmapped; key_held stays 0; no event.
5. FIFO full, pop asserted in the same cycle as a new make -> count stays 4; no overflow; the head advances.
6. With keys held and FIFO non-empty, pulse clear coincident with scan_valid=F0 -> key_held=0, evt_valid=0, evt_overflow=0; the following byte 1D acts as a make (not a break).
